alu_arbiter: RTL

Shares one instance of the team's combinational ALU between two independent requesters (requester 0: pipeline execute path; requester 1: auxiliary/address-compute path). Each requester offers an opcode and two operands on a valid/ready handshake. The arbiter grants one per cycle with round-robin fairness and registers the ALU outputs into a single-entry response buffer with its own valid/ready handshake. Throughput is one operation per cycle when the consumer never stalls.

---
 rtl/alu_defs.sv | 29 ++
 rtl/alu_arbiter_alu.sv | 49 ++++
 rtl/alu_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared ALU/arbiter definitions: opcode encodings, opcode width and
// response-buffer state encodings.
package alu_defs;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_SLL = 4'd0;
    localparam logic [OP_W-1:0] OP_SRL = 4'd1;
    localparam logic [OP_W-1:0] OP_SRA = 4'd2;
    localparam logic [OP_W-1:0] OP_ADD = 4'd3;
    localparam logic [OP_W-1:0] OP_SUB = 4'd4;
    localparam logic [OP_W-1:0] OP_AND = 4'd5;
    localparam logic [OP_W-1:0] OP_OR  = 4'd6;
    localparam logic [OP_W-1:0] OP_XOR = 4'd7;
    localparam logic [OP_W-1:0] OP_NOR = 4'd8;
    localparam logic [OP_W-1:0] OP_SLT = 4'd9;
    localparam logic [OP_W-1:0] OP_MAX = 4'd9;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Opcodes above OP_MAX fall through to the ALU default response.
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op > OP_MAX);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU. Works on an N+1 bit extended result; bit N is the
// carry/borrow reported as overflow. Shifts move bus_b by bus_a[log2 N-1:0].
module alu_arbiter_alu
    import alu_defs::*;
#(
    parameter int N = 32
) (
    input  logic [OP_W-1:0] op,
    input  logic [N-1:0]    bus_a,
    input  logic [N-1:0]    bus_b,
    output logic [N-1:0]    result,
    output logic            zero,
    output logic            overflow
);

    localparam int SH_W = $clog2(N);

    logic [SH_W-1:0] shamt_s;
    logic [N-1:0]    sra_s;
    logic            slt_s;
    logic [N:0]      ext_s;

    assign shamt_s = bus_a[SH_W-1:0];
    assign sra_s   = $signed(bus_b) >>> shamt_s;
    assign slt_s   = ($signed(bus_a) < $signed(bus_b));

    // Opcode decode into the extended result; illegal opcodes yield zero.
    always_comb begin
        ext_s = {(N+1){1'b0}};
        case (op)
            OP_SLL:  ext_s = {1'b0, bus_b} << shamt_s;
            OP_SRL:  ext_s = {1'b0, bus_b >> shamt_s};
            OP_SRA:  ext_s = {1'b0, sra_s};
            OP_ADD:  ext_s = {1'b0, bus_a} + {1'b0, bus_b};
            OP_SUB:  ext_s = {1'b0, bus_a} - {1'b0, bus_b};
            OP_AND:  ext_s = {1'b0, bus_a & bus_b};
            OP_OR:   ext_s = {1'b0, bus_a | bus_b};
            OP_XOR:  ext_s = {1'b0, bus_a ^ bus_b};
            OP_NOR:  ext_s = {1'b0, ~(bus_a | bus_b)};
            OP_SLT:  ext_s = {{N{1'b0}}, slt_s};
            default: ext_s = {(N+1){1'b0}};
        endcase
    end

    assign result   = ext_s[N-1:0];
    assign zero     = (ext_s[N-1:0] == {N{1'b0}});
    assign overflow = ext_s[N];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// single-entry registered response buffer that passes through on consume.
module alu_arbiter
    import alu_defs::*;
#(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [N-1:0]    req0_a,
    input  logic [N-1:0]    req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [N-1:0]    req1_a,
    input  logic [N-1:0]    req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [N-1:0]    rsp_result,
    output logic            rsp_zero,
    output logic            rsp_overflow,
    output logic            rsp_illegal
);

    state_e          state_r;
    state_e          state_next_s;
    logic            last_grant_r;
    logic            can_accept_s;
    logic            grant_s;
    logic            grant_id_s;
    logic [OP_W-1:0] alu_op_s;
    logic [N-1:0]    alu_a_s;
    logic [N-1:0]    alu_b_s;
    logic [N-1:0]    alu_result_s;
    logic            alu_zero_s;
    logic            alu_overflow_s;

    // Round-robin grant; rst_n gating keeps both ready outputs low in reset.
    always_comb begin
        can_accept_s = (state_r == ST_EMPTY) || rsp_ready;
        grant_s      = 1'b0;
        grant_id_s   = 1'b0;
        if (!rst_n || !can_accept_s) begin
            grant_s    = 1'b0;
            grant_id_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
            grant_s    = 1'b1;
            grant_id_s = ~last_grant_r;
        end else if (req0_valid) begin
            grant_s    = 1'b1;
            grant_id_s = 1'b0;
        end else if (req1_valid) begin
            grant_s    = 1'b1;
            grant_id_s = 1'b1;
        end else begin
            grant_s    = 1'b0;
            grant_id_s = 1'b0;
        end
    end

    assign req0_ready = grant_s && !grant_id_s;
    assign req1_ready = grant_s && grant_id_s;

    // Steer the granted requester's operation into the shared ALU.
    always_comb begin
        alu_op_s = req0_op;
        alu_a_s  = req0_a;
        alu_b_s  = req0_b;
        if (grant_id_s) begin
            alu_op_s = req1_op;
            alu_a_s  = req1_a;
            alu_b_s  = req1_b;
        end else begin
            alu_op_s = req0_op;
            alu_a_s  = req0_a;
            alu_b_s  = req0_b;
        end
    end

    alu_arbiter_alu #(.N(N)) u_alu (
        .op       (alu_op_s),
        .bus_a    (alu_a_s),
        .bus_b    (alu_b_s),
        .result   (alu_result_s),
        .zero     (alu_zero_s),
        .overflow (alu_overflow_s)
    );

    // Response buffer next state: fill on grant, drain on consume without grant.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (grant_s) state_next_s = ST_FULL;
                else         state_next_s = ST_EMPTY;
            end
            ST_FULL: begin
                if (rsp_ready && !grant_s) state_next_s = ST_EMPTY;
                else                       state_next_s = ST_FULL;
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // State register and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_EMPTY;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            if (grant_s) last_grant_r <= grant_id_s;
        end
    end

    // Capture ALU outputs into the response buffer on every handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id       <= 1'b0;
            rsp_result   <= {N{1'b0}};
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_illegal  <= 1'b0;
        end else if (grant_s) begin
            rsp_id       <= grant_id_s;
            rsp_result   <= alu_result_s;
            rsp_zero     <= alu_zero_s;
            rsp_overflow <= alu_overflow_s;
            rsp_illegal  <= op_is_illegal(alu_op_s);
        end
    end

    assign rsp_valid = (state_r == ST_FULL);

endmodule
